data_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate word cache between the MEM-stage load/store port and the

---
 rtl/data_cache.sv | 137 +++++++++++++
 tb/tb_data_cache.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache between the load/store port and data memory.
// Load hits are combinational; a load miss stalls while the line is fetched one word per cycle.
module data_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int WO_W    = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_WIDTH - IDX_W - WO_W - 2;
  localparam int IDX_LSB = 2 + WO_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam logic [WO_W-1:0] LAST_WO = WO_W'(WORDS_PER_LINE - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   data_r [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]        tag_r  [LINES];
  logic [LINES-1:0]        valid_r;
  logic [TAG_W-1:0]        fill_tag_r;
  logic [IDX_W-1:0]        fill_idx_r;
  logic [WO_W-1:0]         cnt_r;
  logic [31:0]             hit_count_r, miss_count_r;

  logic [WO_W-1:0]  wo_s;
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             aligned_s, hit_s, load_hit_s, load_miss_s, store_hit_s, fill_last_s;

  assign wo_s        = addr[IDX_LSB-1:2];
  assign idx_s       = addr[TAG_LSB-1:IDX_LSB];
  assign tag_s       = addr[ADDR_WIDTH-1:TAG_LSB];
  assign aligned_s   = (addr[1:0] == 2'b00);
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign store_hit_s = (state_r == IDLE) && we && aligned_s && hit_s;
  assign fill_last_s = (state_r == FILL) && (cnt_r == LAST_WO);
  assign hit_count   = hit_count_r;
  assign miss_count  = miss_count_r;

  // Next-state and combinational port outputs; stores take priority over loads.
  always_comb begin
    state_s     = state_r;
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr;
    mem_wd      = wdata;
    rdata       = '0;
    load_hit_s  = 1'b0;
    load_miss_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (we) begin
          mem_we = 1'b1;
        end else if (re) begin
          if (!aligned_s) begin
            rdata = mem_rd;
          end else if (hit_s) begin
            rdata      = data_r[idx_s][wo_s];
            load_hit_s = 1'b1;
          end else begin
            stall       = 1'b1;
            load_miss_s = 1'b1;
            state_s     = FILL;
          end
        end else begin
          rdata = '0;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_addr = {fill_tag_r, fill_idx_r, cnt_r, 2'b00};
        if (cnt_r == LAST_WO) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, fill bookkeeping and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      fill_tag_r   <= '0;
      fill_idx_r   <= '0;
      cnt_r        <= '0;
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (load_miss_s) begin
        // Invalidate up front so a half-filled line can never hit.
        valid_r[idx_s] <= 1'b0;
        fill_tag_r     <= tag_s;
        fill_idx_r     <= idx_s;
        cnt_r          <= '0;
      end else if (state_r == FILL) begin
        cnt_r <= cnt_r + 1'b1;
        if (fill_last_s) valid_r[fill_idx_r] <= 1'b1;
      end
      if (load_hit_s && (hit_count_r != 32'hFFFF_FFFF)) hit_count_r <= hit_count_r + 32'd1;
      if (load_miss_s && (miss_count_r != 32'hFFFF_FFFF)) miss_count_r <= miss_count_r + 32'd1;
    end
  end

  // Tag and data arrays are never cleared; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (state_r == FILL) begin
      data_r[fill_idx_r][cnt_r] <= mem_rd;
      if (fill_last_s) tag_r[fill_idx_r] <= fill_tag_r;
    end else if (store_hit_s) begin
      data_r[idx_s][wo_s] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: cycle-by-cycle vector table plus a reset-during-fill sequence,
// with a little-endian byte memory model on the memory side.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] addr, wdata, rdata;
  logic        stall, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] hit_count, miss_count;
  logic        init_mem;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [4096];
  logic [11:0] ma;

  data_cache dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  assign ma     = mem_addr[11:0];
  assign mem_rd = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

  // Byte memory: preload during init, otherwise 32-bit little-endian writes at any byte address.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} <= 32'hDEADBEEF;
      {mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]} <= 32'h11111111;
      {mem[12'h10B], mem[12'h10A], mem[12'h109], mem[12'h108]} <= 32'h22222222;
      {mem[12'h10F], mem[12'h10E], mem[12'h10D], mem[12'h10C]} <= 32'h33333333;
      {mem[12'h183], mem[12'h182], mem[12'h181], mem[12'h180]} <= 32'hA0A0A0A0;
    end else if (mem_we) begin
      {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]} <= mem_wd;
    end
  end

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic st, input logic mw, input logic [31:0] ma_e,
                     input logic [31:0] h, input logic [31:0] m);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.wdata = wd; v.rdata = rd; v.stall = st;
    v.mem_we = mw; v.mem_addr = ma_e; v.hits = h; v.misses = m;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; init_mem = 1'b1; re = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;

    //   re    we    addr          wdata         rdata         st    mwe   mem_addr      hits   misses
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'd0, 32'd0);
    // cold load: one miss cycle, four fill cycles, then the hit
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'd0);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0104, 32'd0, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0108, 32'd0, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_010C, 32'd0, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd1);
    // same-line hit
    add(1'b1, 1'b0, 32'h0000_0108, 32'h0, 32'h2222_2222, 1'b0, 1'b0, 32'h0000_0108, 32'd1, 32'd1);
    // store hit, then read back from the cache
    add(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 32'h0000_0104, 32'd2, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0104, 32'd2, 32'd1);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'd3, 32'd1);
    // misaligned load bypasses the cache: bytes 0x105..0x102
    add(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h5678_DEAD, 1'b0, 1'b0, 32'h0000_0102, 32'd3, 32'd1);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'd3, 32'd1);
    // conflict eviction: 0x100 hits, 0x180 evicts it, 0x100 misses again
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 32'd3, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0180, 32'd4, 32'd1);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0180, 32'd4, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0184, 32'd4, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0188, 32'd4, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_018C, 32'd4, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'hA0A0_A0A0, 1'b0, 1'b0, 32'h0000_0180, 32'd4, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 32'd5, 32'd2);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 32'd5, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0104, 32'd5, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0108, 32'd5, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_010C, 32'd5, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 32'd5, 32'd3);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'd6, 32'd3);
    // store miss writes memory only; the following load must miss
    add(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 32'd6, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 32'd6, 32'd3);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 32'd6, 32'd4);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0204, 32'd6, 32'd4);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0208, 32'd6, 32'd4);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_020C, 32'd6, 32'd4);
    add(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_0200, 32'd6, 32'd4);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'd7, 32'd4);

    foreach (vecs[i]) begin
      re = vecs[i].re; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("row%0d_rdata", i),    rdata,             vecs[i].rdata);
      check($sformatf("row%0d_stall", i),    {31'd0, stall},    {31'd0, vecs[i].stall});
      check($sformatf("row%0d_mem_we", i),   {31'd0, mem_we},   {31'd0, vecs[i].mem_we});
      check($sformatf("row%0d_mem_addr", i), mem_addr,          vecs[i].mem_addr);
      check($sformatf("row%0d_hits", i),     hit_count,         vecs[i].hits);
      check($sformatf("row%0d_misses", i),   miss_count,        vecs[i].misses);
      @(negedge clk);
    end

    // Reset on the second fill cycle of a miss to 0x300.
    re = 1'b1; we = 1'b0; addr = 32'h0000_0300;
    #1 check("rst_miss_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); #1 check("rst_fill1_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); rst = 1'b1;
    #1 check("rst_fill2_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); rst = 1'b0; re = 1'b0;
    #1;
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);
    check("post_rst_hits", hit_count, 32'd0);
    check("post_rst_misses", miss_count, 32'd0);

    // 0x100 was cached before reset; it must now miss with the full stall.
    @(negedge clk); re = 1'b1; addr = 32'h0000_0100;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    check("reload_stall_cycles", n, 32'd5);
    check("reload_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk); re = 1'b0;
    #1;
    check("reload_hits", hit_count, 32'd1);
    check("reload_misses", miss_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
